// File: rtl/fifo_rd_packer.sv
// Read-side packer for the async FIFO: pops DSIZE-bit entries in the rclk
// domain and emits RATIO-lane words on a valid/ready stream.
module fifo_rd_packer #(
    parameter int DSIZE   = 8,
    parameter int RATIO   = 4,
    parameter int TIMEOUT = 16,
    parameter int CW      = 16,
    localparam int LW     = $clog2(RATIO + 1),
    localparam int W      = DSIZE * RATIO
) (
    input  logic             rclk,
    input  logic             rrst_n,
    input  logic [DSIZE-1:0] rdata,
    input  logic             rempty,
    output logic             rinc,
    input  logic             flush,
    output logic [W-1:0]     out_data,
    output logic [LW-1:0]    out_lanes,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    pkt_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [LW-1:0] LAST = LW'(RATIO - 1);

    typedef enum logic {FILL, EMIT} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [LW-1:0]   idx;
    logic [TW-1:0]   timer;
    logic            pop;
    logic            tmo;
    logic            idle_go;
    logic            pop_go;

    assign pop     = rinc;
    assign tmo     = (TIMEOUT != 0) && (timer == TMAX);
    assign idle_go = (idx != '0) && !pop && (flush || tmo);
    assign pop_go  = pop && ((idx == LAST) || flush);

    // State register
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            FILL: begin
                if (pop_go || idle_go) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // Pop strobe never depends on out_ready; reset holds it low
    always_comb begin
        rinc = 1'b0;
        unique case (state)
            FILL:    rinc = rrst_n && !rempty;
            EMIT:    rinc = 1'b0;
            default: rinc = 1'b0;
        endcase
    end

    // out_data doubles as lane storage; cleared on acceptance so
    // partial words carry zero upper lanes.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            idx       <= '0;
            timer     <= '0;
            out_data  <= '0;
            out_lanes <= '0;
            out_valid <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (pop) begin
                        out_data[int'(idx)*DSIZE +: DSIZE] <= rdata;
                        idx   <= idx + LW'(1);
                        timer <= '0;
                        if (pop_go) begin
                            out_valid <= 1'b1;
                            out_lanes <= idx + LW'(1);
                        end
                    end else if (idx != '0) begin
                        if (idle_go) begin
                            out_valid <= 1'b1;
                            out_lanes <= idx;
                        end else begin
                            timer <= timer + TW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        idx       <= '0;
                        timer     <= '0;
                        if (pkt_cnt != '1) begin
                            pkt_cnt <= pkt_cnt + CW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Scoreboard bench for fifo_rd_packer: FIFO model feeds the DUT,
// expected words are queued at stimulus time and checked on acceptance.
module tb_fifo_rd_packer;

    localparam int DSIZE   = 8;
    localparam int RATIO   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = 3;
    localparam int LW      = $clog2(RATIO + 1);
    localparam int W       = DSIZE * RATIO;
    localparam int CMAX    = (1 << CW) - 1;

    logic             rclk;
    logic             rrst_n;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             rinc;
    logic             flush;
    logic [W-1:0]     out_data;
    logic [LW-1:0]    out_lanes;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    pkt_cnt;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [LW-1:0] lanes;
    } exp_t;

    exp_t             exp_q[$];
    logic [DSIZE-1:0] fifo_q[$];
    int               n_tests = 0;
    int               n_fail  = 0;
    int               exp_cnt = 0;
    bit               pop_pending;

    fifo_rd_packer #(
        .DSIZE(DSIZE), .RATIO(RATIO), .TIMEOUT(TIMEOUT), .CW(CW)
    ) dut (
        .rclk(rclk), .rrst_n(rrst_n), .rdata(rdata), .rempty(rempty),
        .rinc(rinc), .flush(flush), .out_data(out_data),
        .out_lanes(out_lanes), .out_valid(out_valid),
        .out_ready(out_ready), .pkt_cnt(pkt_cnt)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO model: pop on the edge where rinc was high
    initial begin
        rempty = 1'b1;
        rdata  = '0;
        forever begin
            @(negedge rclk);
            pop_pending = rinc;
            @(posedge rclk);
            if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
            #2;
            rempty = (fifo_q.size() == 0);
            rdata  = rempty ? '0 : fifo_q[0];
        end
    end

    // Output monitor: scoreboard compare and pkt_cnt model
    initial begin
        exp_t e;
        forever begin
            @(negedge rclk);
            if (rrst_n) begin
                n_tests++;
                if (pkt_cnt !== CW'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL pkt_cnt: got %0d expected %0d", pkt_cnt, exp_cnt);
                end
                if (out_valid && out_ready) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_word: got %h lanes %0d expected none",
                                 out_data, out_lanes);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.data || out_lanes !== e.lanes) begin
                            n_fail++;
                            $display("FAIL word: got %h lanes %0d expected %h lanes %0d",
                                     out_data, out_lanes, e.data, e.lanes);
                        end
                    end
                    exp_cnt = (exp_cnt == CMAX) ? CMAX : exp_cnt + 1;
                end
            end
        end
    end

    task automatic push_full(input logic [DSIZE-1:0] v0, input logic [DSIZE-1:0] step,
                             input int nwords);
        logic [W-1:0]     d;
        logic [DSIZE-1:0] v;
        for (int w = 0; w < nwords; w++) begin
            d = '0;
            for (int l = 0; l < RATIO; l++) begin
                v = v0 + step * DSIZE'(w * RATIO + l);
                fifo_q.push_back(v);
                d[l*DSIZE +: DSIZE] = v;
            end
            exp_q.push_back(exp_t'{data: d, lanes: LW'(RATIO)});
        end
    endtask

    task automatic wait_drain(input int lim);
        bit done = 0;
        for (int c = 0; c < lim && !done; c++) begin
            @(negedge rclk);
            if (fifo_q.size() == 0 && exp_q.size() == 0 && !out_valid) done = 1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL drain_timeout: fifo %0d words %0d left expected 0 0",
                     fifo_q.size(), exp_q.size());
        end
    endtask

    task automatic test_reset;
        rrst_n    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        exp_cnt   = 0;
        #12;
        n_tests++;
        if ({rinc, out_valid, out_data, out_lanes, pkt_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got rinc %b v %b d %h l %0d cnt %0d expected all 0",
                     rinc, out_valid, out_data, out_lanes, pkt_cnt);
        end
        @(posedge rclk); #1;
        rrst_n = 1'b1;
    endtask

    task automatic test_full_words;
        int nr = 0;
        int t1 = -1;
        int t2 = -1;
        @(posedge rclk); #1;
        out_ready = 1'b1;
        push_full(8'h11, 8'h11, 2);
        for (int c = 0; c < 40; c++) begin
            @(negedge rclk);
            if (rinc && t1 < 0) nr++;
            if (out_valid && t1 < 0) t1 = c;
            else if (out_valid && t2 < 0 && c > t1 + 1) t2 = c;
        end
        n_tests++;
        if (nr != RATIO) begin
            n_fail++;
            $display("FAIL full_rinc_cycles: got %0d expected %0d", nr, RATIO);
        end
        n_tests++;
        if (t1 != RATIO) begin
            n_fail++;
            $display("FAIL full_latency: got %0d expected %0d", t1, RATIO);
        end
        n_tests++;
        if (t2 - t1 != RATIO + 1) begin
            n_fail++;
            $display("FAIL full_period: got %0d expected %0d", t2 - t1, RATIO + 1);
        end
        n_tests++;
        if (pkt_cnt !== CW'(2)) begin
            n_fail++;
            $display("FAIL full_pkt_cnt: got %0d expected 2", pkt_cnt);
        end
    endtask

    task automatic test_timeout;
        int n = 0;
        @(posedge rclk); #1;
        out_ready = 1'b0;
        fifo_q.push_back(8'hA1);
        fifo_q.push_back(8'hB2);
        exp_q.push_back(exp_t'{data: W'(32'h0000B2A1), lanes: LW'(2)});
        for (int c = 0; c < 10; c++) begin
            @(posedge rclk); #1;
            if (fifo_q.size() == 0) break;
        end
        for (int c = 0; c < 40; c++) begin
            @(posedge rclk); #1;
            n++;
            if (out_valid) break;
        end
        n_tests++;
        if (n != TIMEOUT) begin
            n_fail++;
            $display("FAIL timeout_cycles: got %0d expected %0d", n, TIMEOUT);
        end
        out_ready = 1'b1;
        wait_drain(20);
    endtask

    task automatic test_flush;
        bit seen = 0;
        @(posedge rclk); #1;
        out_ready = 1'b1;
        fifo_q.push_back(8'hC1);
        fifo_q.push_back(8'hC2);
        fifo_q.push_back(8'hC3);
        exp_q.push_back(exp_t'{data: W'(32'h00C3C2C1), lanes: LW'(3)});
        @(posedge rclk); #1;
        @(posedge rclk); #1;
        flush = 1'b1;
        @(posedge rclk); #1;
        flush = 1'b0;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_with_pop: got valid %b expected 1", out_valid);
        end
        wait_drain(20);
        repeat (3) @(posedge rclk);
        #1 flush = 1'b1;
        @(posedge rclk); #1;
        flush = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            if (out_valid) seen = 1;
        end
        n_tests++;
        if (seen) begin
            n_fail++;
            $display("FAIL flush_idle: got valid 1 expected 0");
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] held;
        bit           bad = 0;
        @(posedge rclk); #1;
        out_ready = 1'b0;
        push_full(8'h01, 8'h01, 2);
        for (int c = 0; c < 20; c++) begin
            @(posedge rclk); #1;
            if (out_valid) break;
        end
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge rclk);
            if (out_data !== held || rinc !== 1'b0 || out_valid !== 1'b1) bad = 1;
        end
        n_tests++;
        if (bad || held !== W'(32'h04030201)) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %h expected 04030201 held with rinc 0",
                     held);
        end
        @(posedge rclk); #1;
        out_ready = 1'b1;
        @(posedge rclk);
        @(negedge rclk);
        n_tests++;
        if (rinc !== 1'b1) begin
            n_fail++;
            $display("FAIL backpressure_resume: got rinc %b expected 1", rinc);
        end
        wait_drain(30);
    endtask

    task automatic test_reset_midword;
        @(posedge rclk); #1;
        out_ready = 1'b1;
        fifo_q.push_back(8'hE1);
        fifo_q.push_back(8'hE2);
        for (int c = 0; c < 10; c++) begin
            @(posedge rclk); #1;
            if (fifo_q.size() == 0) break;
        end
        rrst_n  = 1'b0;
        exp_cnt = 0;
        #1;
        n_tests++;
        if ({rinc, out_valid, out_data, out_lanes, pkt_cnt} !== '0) begin
            n_fail++;
            $display("FAIL midword_reset: got d %h l %0d v %b cnt %0d expected all 0",
                     out_data, out_lanes, out_valid, pkt_cnt);
        end
        @(posedge rclk); #1;
        rrst_n = 1'b1;
        push_full(8'hD1, 8'h01, 1);
        wait_drain(30);
    endtask

    task automatic test_saturation;
        @(posedge rclk); #1;
        out_ready = 1'b1;
        push_full(8'h20, 8'h01, CMAX + 2);
        wait_drain(200);
        n_tests++;
        if (pkt_cnt !== CW'(CMAX)) begin
            n_fail++;
            $display("FAIL pkt_cnt_saturate: got %0d expected %0d", pkt_cnt, CMAX);
        end
    endtask

    initial begin
        test_reset();
        test_full_words();
        test_timeout();
        test_flush();
        test_backpressure();
        test_reset_midword();
        test_saturation();
        repeat (2) @(posedge rclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
